dilated_tap_cache: RTL and testbench



---
 rtl/dilated_tap_cache.sv | 107 ++++++++++
 tb/tb_dilated_tap_cache.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dilated_tap_cache.sv
// dilated_tap_cache
//   Streaming history cache in front of a dilated causal convolution dot
//   product. Each accepted C-channel vector x(t) is emitted as the packed
//   operand {x(t-DILATION), x(t)}. The tap is zero until DILATION vectors
//   have been seen since the last reset/clear (causal zero padding).
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-low reset
//   in_data     in   C*W   current vector x(t), channel 0 in the MSBs
//   in_v        in   1     in_data valid
//   in_ready    out  1     vector can be accepted this cycle
//   clear       in   1     synchronous history clear (sequence start)
//   out_packed  out  2*C*W {x(t-DILATION), x(t)}
//   out_v       out  1     out_packed valid
//   out_ready   in   1     downstream consumes out_packed this cycle
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and data stable until that edge;
// ready may depend combinationally on the other side's state.
module dilated_tap_cache #(
    parameter int W        = 16,
    parameter int C        = 4,
    parameter int DILATION = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [C*W-1:0]     in_data,
    input  logic               in_v,
    output logic               in_ready,
    input  logic               clear,
    output logic [2*C*W-1:0]   out_packed,
    output logic               out_v,
    input  logic               out_ready
);

    localparam int PW = (DILATION > 1) ? $clog2(DILATION) : 1;
    localparam int FW = $clog2(DILATION + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DILATION - 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(DILATION);

    // Output-register occupancy; out_v is a direct decode of this register.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]        fill_q, fill_d;
    logic [2*C*W-1:0]     out_packed_q, out_packed_d;
    logic [C*W-1:0]       mem [0:DILATION-1];
    logic [C*W-1:0]       tap;
    logic                 accept;

    // Single output stage: accept when empty or when the held word leaves now.
    assign in_ready = !clear && ((state_q == ST_EMPTY) || out_ready);
    assign accept   = in_v && in_ready;

    // The slot about to be overwritten holds x(t-DILATION) once the ring is
    // full; stale contents after a clear are masked by fill.
    assign tap = (fill_q == FILL_MAX) ? mem[wr_ptr_q] : '0;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        fill_d       = fill_q;
        out_packed_d = out_packed_q;
        if (clear) begin
            state_d  = ST_EMPTY;
            wr_ptr_d = '0;
            fill_d   = '0;
        end else if (accept) begin
            state_d      = ST_FULL;
            out_packed_d = {tap, in_data};
            wr_ptr_d     = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            fill_d       = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
        end else if ((state_q == ST_FULL) && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_EMPTY;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            out_packed_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            out_packed_q <= out_packed_d;
        end
    end

    // History storage is deliberately not reset; fill gates its use.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    assign out_v      = (state_q == ST_FULL);
    assign out_packed = out_packed_q;

endmodule

// File: tb/tb_dilated_tap_cache.sv
module tb_dilated_tap_cache;

  localparam int W  = 16;
  localparam int C  = 4;
  localparam int CW = C * W;
  localparam int PW = 2 * CW;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DILATION = 4 instance
  logic [CW-1:0] in_data   = '0;
  logic          in_v      = 1'b0;
  logic          in_ready;
  logic          clear     = 1'b0;
  logic [PW-1:0] out_packed;
  logic          out_v;
  logic          out_ready = 1'b1;

  // DILATION = 1 instance
  logic [CW-1:0] in_data1   = '0;
  logic          in_v1      = 1'b0;
  logic          in_ready1;
  logic          clear1     = 1'b0;
  logic [PW-1:0] out_packed1;
  logic          out_v1;
  logic          out_ready1 = 1'b1;

  dilated_tap_cache #(.W(W), .C(C), .DILATION(4)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_v(in_v), .in_ready(in_ready),
    .clear(clear),
    .out_packed(out_packed), .out_v(out_v), .out_ready(out_ready)
  );

  dilated_tap_cache #(.W(W), .C(C), .DILATION(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_data(in_data1), .in_v(in_v1), .in_ready(in_ready1),
    .clear(clear1),
    .out_packed(out_packed1), .out_v(out_v1), .out_ready(out_ready1)
  );

  // scoreboard
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] exp1_q[$];
  int checks   = 0;
  int failures = 0;
  int last_wait = 0;

  // s_n: every channel equals n
  function automatic logic [CW-1:0] sv(input int n);
    logic [W-1:0] e;
    e = n[W-1:0];
    return {C{e}};
  endfunction

  // expected packed word; tap_n == 0 means zero tap
  function automatic logic [PW-1:0] pk(input int tap_n, input int cur_n);
    logic [CW-1:0] t;
    t = (tap_n == 0) ? '0 : sv(tap_n);
    return {t, sv(cur_n)};
  endfunction

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitors: a word is consumed at the rising edge after a negedge that
  // shows valid && ready
  initial begin
    forever begin
      @(negedge clk);
      if (rst && out_v && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL d4_unexpected_output: got %h expected nothing", out_packed);
        end else begin
          check("d4_out_packed", out_packed, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst && out_v1 && out_ready1) begin
        if (exp1_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL d1_unexpected_output: got %h expected nothing", out_packed1);
        end else begin
          check("d1_out_packed", out_packed1, exp1_q.pop_front());
        end
      end
    end
  end

  // drivers: called just after a rising edge; return just after the accept edge
  task automatic send(input int n);
    int waited;
    waited = 0;
    in_data = sv(n);
    in_v = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    last_wait = waited;
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL d4_send_timeout: got in_ready=0 expected 1 for s%0d", n);
    end
    @(posedge clk);
    #1;
    in_v = 1'b0;
  endtask

  task automatic send1(input int n);
    int waited;
    waited = 0;
    in_data1 = sv(n);
    in_v1 = 1'b1;
    @(negedge clk);
    while (!in_ready1 && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready1) begin
      checks++;
      failures++;
      $display("FAIL d1_send_timeout: got in_ready=0 expected 1 for s%0d", n);
    end
    @(posedge clk);
    #1;
    in_v1 = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    // power-on reset
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_v", PW'(out_v), PW'(0));
    check("rst_out_packed", out_packed, '0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", PW'(in_ready), PW'(1));

    // priming and wrap: s1..s9
    for (int n = 1; n <= 9; n++) begin
      exp_q.push_back(pk((n <= 4) ? 0 : n - 4, n));
      send(n);
    end
    idle(2);

    // backpressure on {s2,s6}
    pulse_clear();
    for (int n = 1; n <= 6; n++) begin
      exp_q.push_back(pk((n <= 4) ? 0 : n - 4, n));
      send(n);
    end
    out_ready = 1'b0;
    in_data = sv(7);
    in_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_packed", out_packed, pk(2, 6));
      check("bp_out_v", PW'(out_v), PW'(1));
      check("bp_in_ready", PW'(in_ready), PW'(0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    exp_q.push_back(pk(3, 7));
    send(7);
    check("bp_s7_wait", PW'(last_wait), PW'(0));
    idle(2);

    // clear beats a simultaneous input
    clear = 1'b1;
    in_data = sv(10);
    in_v = 1'b1;
    @(negedge clk);
    check("clr_in_ready", PW'(in_ready), PW'(0));
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_v = 1'b0;
    @(negedge clk);
    check("clr_out_v", PW'(out_v), PW'(0));
    @(posedge clk);
    #1;
    for (int n = 11; n <= 15; n++) begin
      exp_q.push_back(pk((n <= 14) ? 0 : n - 4, n));
      send(n);
    end
    idle(2);

    // reset mid-stream
    pulse_clear();
    for (int n = 1; n <= 5; n++) begin
      exp_q.push_back(pk((n <= 4) ? 0 : n - 4, n));
      send(n);
    end
    send(6);
    out_ready = 1'b0;
    @(negedge clk);
    check("mid_held", out_packed, pk(2, 6));
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_out_v", PW'(out_v), PW'(0));
    check("mid_rst_out_packed", out_packed, '0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_in_ready", PW'(in_ready), PW'(1));
    out_ready = 1'b1;
    for (int n = 7; n <= 11; n++) begin
      exp_q.push_back(pk((n <= 10) ? 0 : n - 4, n));
      send(n);
    end
    idle(2);

    // DILATION = 1
    for (int n = 1; n <= 3; n++) begin
      exp1_q.push_back(pk(n - 1, n));
      send1(n);
    end

    // drain, bounded
    for (int i = 0; i < 20 && (exp_q.size() != 0 || exp1_q.size() != 0); i++) begin
      @(posedge clk);
    end
    check("d4_queue_left", PW'(exp_q.size()), PW'(0));
    check("d1_queue_left", PW'(exp1_q.size()), PW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
